udp_packet_scheduler: RTL and testbench
=======================================

Name: udp_packet_scheduler

Overview:
Sequences the UDP image-transmit path: splits each image into fixed-size UDP packets and decides when each packet launches. It watches the image FIFO fill level and issues a start strobe to the IP/UDP sender. It drives that sender's frame_index, tx_data_length and tx_total_length, then tracks e_txen to detect packet completion and enforce an inter-packet gap. It sits between the camera-side image FIFO and the udp transmit block.

Parameters:
PAYLOAD_BYTES, 1024, payload bytes per full packet; range 1..2047 (must fit fifo_data_count).
IMAGE_BYTES, 614400, bytes per image (640x480x16bit).
IFG_CYCLES, 64, idle cycles required after e_txen falls before the next start; minimum 1.
TXEN_TIMEOUT, 4096, cycles allowed from tx_start until e_txen rises.

Ports:
e_rxc  in  1  Ethernet GMII clock; the single clock for all logic.
reset_n  in  1  asynchronous, active-low reset.
image_start  in  1  one-cycle pulse: a new image begins entering the FIFO.
fifo_data_count  in  11  current image FIFO occupancy in bytes.
e_txen  in  1  transmit-enable from the sender; high while a frame is on the wire.
tx_start  out  1  one-cycle pulse that launches one packet.
frame_index  out  11  packet number within the current image, starting at 0.
tx_data_length  out  16  UDP length = payload + 8.
tx_total_length  out  16  IP total length = payload + 28.
last_packet  out  1  high while the current packet is the final one of the image.
image_done  out  1  one-cycle pulse after the last packet's gap completes.
tx_timeout  out  1  one-cycle pulse when e_txen fails to rise within TXEN_TIMEOUT.
busy  out  1  high in every state except IDLE.

Behaviour:
- Derived constants: NPKT = ceil(IMAGE_BYTES/PAYLOAD_BYTES). LAST_LEN = IMAGE_BYTES - (NPKT-1)*PAYLOAD_BYTES. cur_len = LAST_LEN when frame_index == NPKT-1, otherwise PAYLOAD_BYTES.
- Reset values: all outputs 0, state IDLE, gap and timeout counters 0.
- Length outputs are registered and change only on entry to START. They hold stable through SENDING and GAP.
- e_txen is synchronous to e_rxc; no synchronizer is used.
- States:
  - IDLE: on image_start -> WAIT_DATA, frame_index = 0.
  - WAIT_DATA: when fifo_data_count >= cur_len -> START. Comparison is unsigned 11-bit.
  - START: one cycle. Assert tx_start. Load tx_data_length = cur_len+8, tx_total_length = cur_len+28, last_packet = (frame_index == NPKT-1). Clear timeout counter. -> WAIT_TXEN.
  - WAIT_TXEN:
    - e_txen = 1 -> SENDING.
    - If the counter reaches TXEN_TIMEOUT-1 with e_txen still 0: pulse tx_timeout and go -> WAIT_DATA. frame_index is not incremented, so the same packet is retried.
  - SENDING: on e_txen = 0 -> GAP, gap counter cleared.
  - GAP: count IFG_CYCLES cycles, then:
    - If last_packet: pulse image_done, clear last_packet, frame_index = 0 -> IDLE.
    - Otherwise: frame_index + 1 -> WAIT_DATA.
- tx_start is exactly one cycle wide. It is never re-asserted before GAP completes.
- image_start during IDLE, WAIT_DATA or GAP (non-final packet): frame_index = 0, next state WAIT_DATA. The pending gap still completes first if in GAP.
- image_start during START, WAIT_TXEN or SENDING: latched in a pending flag, applied at GAP exit as above. The in-flight packet is never truncated.
- image_start coinciding with GAP exit of the last packet: image_done still pulses, then -> WAIT_DATA with index 0 instead of IDLE.
- e_txen high while in IDLE or WAIT_DATA is ignored.
- Asynchronous reset mid-packet returns to IDLE immediately. The sender's own frame is not aborted by this block.

Test Plan:
- IMAGE_BYTES=2500, PAYLOAD_BYTES=1024, FIFO held at 2047, e_txen modelled high 30 cycles, 2 cycles after tx_start:
  - Expect 3 tx_start pulses with frame_index 0,1,2.
  - Lengths 1032/1052, 1032/1052, then 460/480.
  - last_packet set only on index 2; one image_done pulse; then IDLE.
- FIFO count 1023 with PAYLOAD 1024 -> no tx_start. Step the count to 1024 -> tx_start 2 cycles later (WAIT_DATA -> START).
- IFG_CYCLES=64: e_txen falls at cycle T -> the next tx_start is no earlier than T+65, even with the FIFO full.
- e_txen never rises, TXEN_TIMEOUT=16:
  - tx_timeout pulses 16 cycles after tx_start.
  - The retry tx_start carries the same frame_index.
- image_start pulsed while SENDING packet 1:
  - Packet completes with unchanged lengths.
  - After the gap, frame_index = 0 and the next tx_start follows.
- reset_n asserted low mid-SENDING -> all outputs 0 asynchronously. After release, no tx_start until image_start.

Source files
------------

// File: rtl/udp_packet_scheduler.sv
// rtl/udp_packet_scheduler.sv - splits an image into UDP packets and paces their launch
//
// Ports:
//   e_rxc            GMII clock, single clock for all logic
//   reset_n          asynchronous active-low reset
//   image_start      one-cycle pulse, a new image begins entering the FIFO
//   fifo_data_count  image FIFO occupancy in bytes
//   e_txen           sender transmit-enable, high while a frame is on the wire
//   tx_start         one-cycle launch pulse for one packet
//   frame_index      packet number within the current image
//   tx_data_length   UDP length (payload + 8)
//   tx_total_length  IP total length (payload + 28)
//   last_packet      current packet is the final one of the image
//   image_done       one-cycle pulse after the last packet's gap
//   tx_timeout       one-cycle pulse when e_txen never rose after a launch
//   busy             high in every state except idle
module udp_packet_scheduler #(
  parameter int PAYLOAD_BYTES = 1024,
  parameter int IMAGE_BYTES   = 614400,
  parameter int IFG_CYCLES    = 64,
  parameter int TXEN_TIMEOUT  = 4096
) (
  input  logic        e_rxc,
  input  logic        reset_n,
  input  logic        image_start,
  input  logic [10:0] fifo_data_count,
  input  logic        e_txen,
  output logic        tx_start,
  output logic [10:0] frame_index,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        last_packet,
  output logic        image_done,
  output logic        tx_timeout,
  output logic        busy
);

  localparam int NPKT     = (IMAGE_BYTES + PAYLOAD_BYTES - 1) / PAYLOAD_BYTES;
  localparam int LAST_LEN = IMAGE_BYTES - (NPKT - 1) * PAYLOAD_BYTES;
  localparam int GW       = $clog2(IFG_CYCLES + 1);
  localparam int TW       = $clog2(TXEN_TIMEOUT + 1);

  localparam logic [10:0]   LAST_IDX = 11'(NPKT - 1);
  localparam logic [10:0]   FULL_LEN = 11'(PAYLOAD_BYTES);
  localparam logic [10:0]   TAIL_LEN = 11'(LAST_LEN);
  localparam logic [GW-1:0] GAP_END  = GW'(IFG_CYCLES - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TXEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_START, S_WAIT_TXEN, S_SENDING, S_GAP
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          pend, pend_nxt;
  logic [10:0]   idx_nxt;
  logic [15:0]   dlen_nxt, tlen_nxt;
  logic          last_nxt, start_nxt, done_nxt, to_nxt;
  logic          is_last;
  logic [10:0]   cur_len;
  logic          restart;

  assign is_last = (frame_index == LAST_IDX);
  assign cur_len = is_last ? TAIL_LEN : FULL_LEN;
  // A new image requested now or earlier (held while a packet was in flight)
  assign restart = image_start | pend;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    to_cnt_nxt  = to_cnt;
    pend_nxt    = pend;
    idx_nxt     = frame_index;
    dlen_nxt    = tx_data_length;
    tlen_nxt    = tx_total_length;
    last_nxt    = last_packet;
    start_nxt   = 1'b0;
    done_nxt    = 1'b0;
    to_nxt      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (image_start) begin
          state_nxt = S_WAIT_DATA;
          idx_nxt   = '0;
        end
      end
      S_WAIT_DATA: begin
        // A fresh image wins over a launch of the old index this cycle
        if (image_start) begin
          idx_nxt = '0;
        end else if (fifo_data_count >= cur_len) begin
          state_nxt  = S_START;
          dlen_nxt   = 16'(cur_len) + 16'd8;
          tlen_nxt   = 16'(cur_len) + 16'd28;
          last_nxt   = is_last;
          to_cnt_nxt = '0;
        end
      end
      S_START: begin
        start_nxt = 1'b1;
        state_nxt = S_WAIT_TXEN;
        if (image_start) pend_nxt = 1'b1;
      end
      S_WAIT_TXEN: begin
        if (image_start) pend_nxt = 1'b1;
        if (e_txen) begin
          state_nxt = S_SENDING;
        end else if (to_cnt == TO_END) begin
          // Retry the same packet; frame_index is left untouched
          to_nxt    = 1'b1;
          state_nxt = S_WAIT_DATA;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      S_SENDING: begin
        if (image_start) pend_nxt = 1'b1;
        if (!e_txen) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_END) begin
          pend_nxt = 1'b0;
          if (last_packet) begin
            done_nxt  = 1'b1;
            last_nxt  = 1'b0;
            idx_nxt   = '0;
            state_nxt = restart ? S_WAIT_DATA : S_IDLE;
          end else begin
            idx_nxt   = restart ? 11'd0 : frame_index + 11'd1;
            state_nxt = S_WAIT_DATA;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
          if (image_start) pend_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      gap_cnt         <= '0;
      to_cnt          <= '0;
      pend            <= 1'b0;
      frame_index     <= '0;
      tx_data_length  <= '0;
      tx_total_length <= '0;
      last_packet     <= 1'b0;
      tx_start        <= 1'b0;
      image_done      <= 1'b0;
      tx_timeout      <= 1'b0;
    end else begin
      state           <= state_nxt;
      gap_cnt         <= gap_cnt_nxt;
      to_cnt          <= to_cnt_nxt;
      pend            <= pend_nxt;
      frame_index     <= idx_nxt;
      tx_data_length  <= dlen_nxt;
      tx_total_length <= tlen_nxt;
      last_packet     <= last_nxt;
      tx_start        <= start_nxt;
      image_done      <= done_nxt;
      tx_timeout      <= to_nxt;
    end
  end

endmodule

// File: tb/tb_udp_packet_scheduler.sv
// tb/tb_udp_packet_scheduler.sv - self-checking bench for udp_packet_scheduler
module tb_udp_packet_scheduler;

  localparam int PAY   = 1024;
  localparam int IMG   = 2500;
  localparam int IFG   = 64;
  localparam int TOUT  = 16;
  localparam int NPKT  = (IMG + PAY - 1) / PAY;

  logic        e_rxc = 1'b0;
  logic        reset_n;
  logic        image_start;
  logic [10:0] fifo_data_count;
  logic        e_txen;
  logic        tx_start;
  logic [10:0] frame_index;
  logic [15:0] tx_data_length, tx_total_length;
  logic        last_packet, image_done, tx_timeout, busy;

  udp_packet_scheduler #(
    .PAYLOAD_BYTES(PAY), .IMAGE_BYTES(IMG), .IFG_CYCLES(IFG), .TXEN_TIMEOUT(TOUT)
  ) dut (
    .e_rxc(e_rxc), .reset_n(reset_n), .image_start(image_start),
    .fifo_data_count(fifo_data_count), .e_txen(e_txen), .tx_start(tx_start),
    .frame_index(frame_index), .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length), .last_packet(last_packet),
    .image_done(image_done), .tx_timeout(tx_timeout), .busy(busy)
  );

  always #5 e_rxc = ~e_rxc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks where the current packet is in its life
  bit m_wait_data, m_launch, m_await, m_air, m_pend, m_last;
  int m_gap_left, m_low, m_idx, m_dlen, m_tlen;
  bit m_start, m_done, m_to;

  function automatic int pkt_len(input int i);
    int rem;
    rem = IMG - i * PAY;
    return (rem < PAY) ? rem : PAY;
  endfunction

  function automatic bit m_busy();
    return m_wait_data | m_launch | m_await | m_air | (m_gap_left > 0);
  endfunction

  task automatic model_reset();
    m_wait_data = 0; m_launch = 0; m_await = 0; m_air = 0; m_pend = 0; m_last = 0;
    m_gap_left = 0; m_low = 0; m_idx = 0; m_dlen = 0; m_tlen = 0;
    m_start = 0; m_done = 0; m_to = 0;
  endtask

  task automatic model_step(input bit is, input int fifo, input bit txen);
    bit restart;
    m_start = 0; m_done = 0; m_to = 0;
    if (m_wait_data) begin
      if (is) m_idx = 0;
      else if (fifo >= pkt_len(m_idx)) begin
        m_dlen = pkt_len(m_idx) + 8;
        m_tlen = pkt_len(m_idx) + 28;
        m_last = (m_idx == NPKT - 1);
        m_wait_data = 0;
        m_launch = 1;
      end
    end else if (m_launch) begin
      m_start = 1; m_launch = 0; m_await = 1; m_low = 0;
      if (is) m_pend = 1;
    end else if (m_await) begin
      if (is) m_pend = 1;
      if (txen) begin
        m_await = 0; m_air = 1;
      end else begin
        m_low++;
        if (m_low == TOUT) begin
          m_to = 1; m_await = 0; m_wait_data = 1;
        end
      end
    end else if (m_air) begin
      if (is) m_pend = 1;
      if (!txen) begin
        m_air = 0; m_gap_left = IFG;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        restart = m_pend | is;
        m_pend = 0;
        if (m_last) begin
          m_done = 1; m_last = 0; m_idx = 0; m_wait_data = restart;
        end else begin
          m_idx = restart ? 0 : m_idx + 1;
          m_wait_data = 1;
        end
      end else if (is) m_pend = 1;
    end else if (is) begin
      m_wait_data = 1; m_idx = 0;
    end
  endtask

  // Sender behaviour and event logs
  bit snd_on = 1, snd_rand = 0, samp_prev = 0;
  int snd_age = -1, snd_delay = 2, snd_len = 30;
  int n_starts = 0, n_done = 0, n_to = 0, last_start_cyc = 0, last_to_cyc = 0;
  int q_st_cyc[$], q_st_idx[$], q_st_dlen[$], q_st_tlen[$], q_st_last[$], q_fall[$];

  task automatic clear_logs();
    q_st_cyc.delete(); q_st_idx.delete(); q_st_dlen.delete();
    q_st_tlen.delete(); q_st_last.delete(); q_fall.delete();
    n_starts = 0; n_done = 0; n_to = 0;
  endtask

  task automatic tick();
    @(negedge e_rxc);
    cyc++;
    if (!reset_n) model_reset();
    else model_step(image_start, int'(fifo_data_count), e_txen);
    check("tx_start", tx_start, m_start);
    check("frame_index", frame_index, m_idx);
    check("tx_data_length", tx_data_length, m_dlen);
    check("tx_total_length", tx_total_length, m_tlen);
    check("last_packet", last_packet, m_last);
    check("image_done", image_done, m_done);
    check("tx_timeout", tx_timeout, m_to);
    check("busy", busy, m_busy());
    if (tx_start === 1'b1) begin
      n_starts++; last_start_cyc = cyc;
      q_st_cyc.push_back(cyc); q_st_idx.push_back(int'(frame_index));
      q_st_dlen.push_back(int'(tx_data_length)); q_st_tlen.push_back(int'(tx_total_length));
      q_st_last.push_back(int'(last_packet));
    end
    if (image_done === 1'b1) n_done++;
    if (tx_timeout === 1'b1) begin n_to++; last_to_cyc = cyc; end
    if (samp_prev && !e_txen) q_fall.push_back(cyc);
    samp_prev = e_txen;
    if (tx_start === 1'b1) begin
      snd_age = 0;
      if (snd_rand) begin
        snd_delay = $urandom_range(1, 6);
        snd_len   = $urandom_range(1, 40);
        snd_on    = ($urandom_range(0, 9) != 0);
      end
    end else if (snd_age >= 0) snd_age++;
    if (snd_age > snd_delay + snd_len + 2) snd_age = -1;
    e_txen = snd_on && snd_age >= snd_delay - 1 && snd_age < snd_delay - 1 + snd_len;
    if (errors >= 40) finish_sim();
  endtask

  task automatic pulse_image();
    image_start = 1'b1;
    tick();
    image_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy !== 1'b0 || m_busy()) && n < 5000) begin tick(); n++; end
    check(name, busy, 0);
  endtask

  int exp_idx[3]  = '{0, 1, 2};
  int exp_dlen[3] = '{1032, 1032, 460};
  int exp_tlen[3] = '{1052, 1052, 480};
  int exp_last[3] = '{0, 0, 1};

  initial begin
    int n, m, c, nf, n0;
    reset_n = 1'b1; image_start = 1'b0; fifo_data_count = '0; e_txen = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_index", frame_index, 0);
    check("rst_dlen", tx_data_length, 0);
    check("rst_tlen", tx_total_length, 0);
    check("rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Whole image with the FIFO full
    clear_logs();
    fifo_data_count = 11'd2047;
    pulse_image();
    n = 0;
    while (!(n_done >= 1 && busy === 1'b0) && n < 2000) begin tick(); n++; end
    check("img_starts", q_st_cyc.size(), 3);
    check("img_done_count", n_done, 1);
    if (q_st_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("img_idx", q_st_idx[i], exp_idx[i]);
        check("img_dlen", q_st_dlen[i], exp_dlen[i]);
        check("img_tlen", q_st_tlen[i], exp_tlen[i]);
        check("img_last", q_st_last[i], exp_last[i]);
      end
      if (q_fall.size() >= 1)
        check("ifg_spacing_ge_65", (q_st_cyc[1] - q_fall[0]) >= 65, 1);
    end

    // FIFO threshold
    clear_logs();
    fifo_data_count = 11'd1023;
    pulse_image();
    for (int i = 0; i < 20; i++) tick();
    check("thresh_no_start", n_starts, 0);
    fifo_data_count = 11'd1024;
    m = cyc;
    n = 0;
    while (n_starts == 0 && n < 10) begin tick(); n++; end
    check("thresh_latency", last_start_cyc - m, 2);
    fifo_data_count = 11'd2047;
    drain("thresh_drain");

    // Sender never answers: timeout then retry of the same packet
    clear_logs();
    snd_on = 0;
    pulse_image();
    n = 0;
    while (n_starts == 0 && n < 50) begin tick(); n++; end
    c = last_start_cyc;
    n = 0;
    while (n_to == 0 && n < 50) begin tick(); n++; end
    check("timeout_latency", last_to_cyc - c, 16);
    snd_on = 1;
    n = 0;
    while (n_starts < 2 && n < 50) begin tick(); n++; end
    check("retry_seen", n_starts, 2);
    if (q_st_idx.size() >= 2) check("retry_idx", q_st_idx[1], 0);
    drain("timeout_drain");

    // New image requested while packet 1 is on the wire
    clear_logs();
    pulse_image();
    n = 0;
    while (!(m_air && m_idx == 1) && n < 500) begin tick(); n++; end
    pulse_image();
    nf = q_fall.size();
    n = 0;
    while (q_fall.size() == nf && n < 200) begin tick(); n++; end
    check("mid_dlen_kept", tx_data_length, 1032);
    check("mid_tlen_kept", tx_total_length, 1052);
    n0 = n_starts;
    n = 0;
    while (n_starts == n0 && n < 200) begin tick(); n++; end
    check("mid_restart_idx", frame_index, 0);
    drain("mid_drain");

    // Asynchronous reset while sending
    clear_logs();
    pulse_image();
    n = 0;
    while (!m_air && n < 100) begin tick(); n++; end
    #2 reset_n = 1'b0;
    #1;
    check("arst_tx_start", tx_start, 0);
    check("arst_frame_index", frame_index, 0);
    check("arst_dlen", tx_data_length, 0);
    check("arst_tlen", tx_total_length, 0);
    check("arst_last", last_packet, 0);
    check("arst_busy", busy, 0);
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    n0 = n_starts;
    for (int i = 0; i < 100; i++) tick();
    check("arst_no_start", n_starts - n0, 0);

    // Randomised traffic
    clear_logs();
    snd_rand = 1;
    for (int i = 0; i < 15000; i++) begin
      image_start = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) fifo_data_count = 11'($urandom_range(0, 2047));
      tick();
    end
    image_start = 1'b0;
    fifo_data_count = 11'd2047;
    drain("random_drain");
    check("random_activity", n_starts > 0, 1);
    finish_sim();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    errors++;
    finish_sim();
  end

endmodule
